// File: rtl/fifo_rd_ptr_empty.sv
// rtl/fifo_rd_ptr_empty.sv - read-domain pointer, Gray pointer export and empty/level status of the async FIFO
//
// Optional feature macro: RD_UNDERFLOW_FLAG_EN (sticky read-while-empty flag).
//
// Ports:
//   clk          read-domain clock
//   rst_n        asynchronous active-low reset
//   rd_inc       read request from the consumer
//   sync_wr_ptr  Gray write pointer, already synchronized into clk
//   rd_accept    rd_inc & ~empty, memory read enable (combinational)
//   rd_addr      binary memory read address
//   rd_ptr       registered Gray read pointer for the write-domain synchronizer
//   empty        registered empty flag
//   almost_empty registered, level <= AE_LEVEL
//   rd_level     registered fill level, 0..2^ADDR_SIZE
//   underflow    sticky read-while-empty flag (0 unless RD_UNDERFLOW_FLAG_EN)

module fifo_rd_ptr_empty #(
    parameter int ADDR_SIZE = 3,
    parameter int PTR_SIZE  = ADDR_SIZE + 1,
    parameter int AE_LEVEL  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_inc,
    input  logic [PTR_SIZE-1:0]  sync_wr_ptr,
    output logic                 rd_accept,
    output logic [ADDR_SIZE-1:0] rd_addr,
    output logic [PTR_SIZE-1:0]  rd_ptr,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [PTR_SIZE-1:0]  rd_level,
    output logic                 underflow
);

    localparam logic [PTR_SIZE-1:0] AE_THRESH = PTR_SIZE'(AE_LEVEL);

    logic [PTR_SIZE-1:0] rd_bin;
    logic [PTR_SIZE-1:0] rd_bin_next;
    logic [PTR_SIZE-1:0] rd_gray_next;
    logic [PTR_SIZE-1:0] wr_bin;
    logic [PTR_SIZE-1:0] level_next;

    // A read while empty is dropped here, so the pointer can never pass the writer.
    assign rd_accept    = rd_inc & ~empty;
    assign rd_bin_next  = rd_bin + {{(PTR_SIZE-1){1'b0}}, rd_accept};
    assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
    assign rd_addr      = rd_bin[ADDR_SIZE-1:0];

    // Gray to binary: each bit is the XOR of itself and every more significant bit.
    always_comb begin
        wr_bin = sync_wr_ptr;
        for (int i = 1; i < PTR_SIZE; i++) begin
            wr_bin = wr_bin ^ (sync_wr_ptr >> i);
        end
    end

    // Level uses the post-read pointer so status reflects the word just consumed.
    assign level_next = wr_bin - rd_bin_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bin       <= '0;
            rd_ptr       <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
        end else begin
            rd_bin       <= rd_bin_next;
            rd_ptr       <= rd_gray_next;
            empty        <= (rd_gray_next == sync_wr_ptr);
            almost_empty <= (level_next <= AE_THRESH);
            rd_level     <= level_next;
        end
    end

`ifdef RD_UNDERFLOW_FLAG_EN
    logic underflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_q <= 1'b0;
        end else if (rd_inc && empty) begin
            underflow_q <= 1'b1;
        end
    end

    assign underflow = underflow_q;
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: doc/fifo_rd_ptr_empty.md
# fifo_rd_ptr_empty

Read-domain pointer and status stage of the team's asynchronous FIFO. It takes the write pointer after it has crossed into the read clock domain through the two-flop pointer synchronizer. It advances the read pointer on accepted reads and drives the FIFO memory read address. It also produces the Gray-coded read pointer that the write-domain synchronizer consumes, plus registered empty, almost-empty and fill-level status.

## Interface
Parameters:
- ADDR_SIZE, 3: FIFO memory address width; depth = 2^ADDR_SIZE.
- PTR_SIZE, ADDR_SIZE+1: pointer width, with one extra wrap bit.
- AE_LEVEL, 1: almost_empty asserts when the level is ≤ AE_LEVEL.

Ports:
- clk  in  1: read-domain clock.
- rst_n  in  1: asynchronous, active-low reset.
- rd_inc  in  1: read request from the consumer.
- sync_wr_ptr  in  PTR_SIZE: Gray write pointer, already synchronized to clk.
- rd_accept  out  1: combinational, rd_inc & ~empty; this is the memory read enable.
- rd_addr  out  ADDR_SIZE: binary read address, equal to rd_bin[ADDR_SIZE-1:0].
- rd_ptr  out  PTR_SIZE: registered Gray read pointer, sent to the write-domain synchronizer.
- empty  out  1: registered empty flag.
- almost_empty  out  1: registered; asserts when level ≤ AE_LEVEL.
- rd_level  out  PTR_SIZE: registered fill level, range 0..2^ADDR_SIZE.
- underflow  out  1: sticky read-while-empty flag (see Configuration).

## Operation
- Internal binary counter rd_bin (PTR_SIZE bits), plus registered Gray copy rd_ptr.
- Next-pointer computation:
  - rd_bin_next = rd_bin + rd_accept, wrapping modulo 2^PTR_SIZE.
  - rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1).
- Registered updates every clk:
  - rd_bin ← rd_bin_next
  - rd_ptr ← rd_gray_next
  - empty ← (rd_gray_next == sync_wr_ptr)
- Level computation:
  - wr_bin is the combinational Gray-to-binary conversion of sync_wr_ptr (prefix XOR from the MSB).
  - rd_level ← (wr_bin − rd_bin_next) mod 2^PTR_SIZE.
  - almost_empty ← (that level ≤ AE_LEVEL).
- A read while empty is ignored: rd_accept=0 and the pointer holds.
- Reset values: rd_bin=0, rd_ptr=0, rd_addr=0, empty=1, almost_empty=1, rd_level=0, underflow=0.
- Reset mid-operation clears all state immediately, whatever the pending read.
- Gray-code rule: rd_ptr changes in at most one bit per clk, including at wrap-around.
- Simultaneous read and sync_wr_ptr change: both are used in the same next-state computation; there is no priority.

## Timing
- Read latency: rd_accept and rd_addr are valid in the request cycle. rd_addr and rd_ptr advance at the next clk edge.
- empty asserts at the clk edge that accepts the last remaining word, with no extra cycle.
- empty deasserts one clk after sync_wr_ptr changes. Including the synchronizer, the total write-to-visible latency is 3 read clocks.
- The flags are pessimistic by design: because the write pointer is stale, empty may be held longer but is never deasserted early.
- rd_level and almost_empty update on the same edge as empty.

## Configuration
- Macro RD_UNDERFLOW_FLAG_EN.
- When defined:
  - underflow sets on any clk where rd_inc=1 and empty=1.
  - It stays set until rst_n is asserted.
- When undefined:
  - underflow is tied to 0 and no flop is built.
  - Pointer behaviour is identical in both cases.

## Test plan
All cases use ADDR_SIZE=3, AE_LEVEL=1.
- Reset: assert rst_n=0 mid-stream -> rd_addr=0, rd_ptr=4'b0000, empty=1, almost_empty=1, rd_level=0 asynchronously.
- Fill visibility: sync_wr_ptr=4'b0010 (3 words) -> one clk later empty=0, rd_level=3, almost_empty=0.
- Drain: three consecutive rd_inc -> rd_ptr steps 0001, 0011, 0010. almost_empty=1 after the 2nd read; empty=1 after the 3rd read; a 4th rd_inc gives rd_accept=0.
- Underflow: rd_inc=1 while empty.
  - With RD_UNDERFLOW_FLAG_EN: underflow=1 and stays set until reset.
  - Without the macro: underflow=0.
  - In both cases rd_ptr is unchanged.
- Full level: rd_bin=0 and sync_wr_ptr=4'b1100 (gray 8) -> rd_level=8, empty=0.
- Wrap-around: run 16 reads with the writer kept ahead -> rd_addr wraps 7→0, rd_ptr goes 1000 (gray 15) → 0000, and every step changes exactly one bit.
